// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential/branch/jump/call/return with a LIFO return stack.
// One-edge latency per stepped op; sticky ovf/unf flags for stack misuse.
module pc_sequencer #(
    parameter int PC_W        = 12,
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           step,
    input  logic [2:0]                     op,
    input  logic [DATA_W-1:0]              cond,
    input  logic [PC_W-1:0]                br_target,
    input  logic [PC_W-1:0]                j_target,
    input  logic                           err_clr,
    output logic [PC_W-1:0]                pc,
    output logic                           taken,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           ovf,
    output logic                           unf
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic [2:0] {
        OP_NEXT = 3'b000,
        OP_BRZ  = 3'b001,
        OP_BRNZ = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            taken_q, taken_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic            push_en;
    logic [AW-1:0]   push_idx;
    logic [AW-1:0]   top_idx;
    logic [PC_W-1:0] pc_inc;
    logic            cond_zero;
    logic            stack_full;
    logic            stack_empty;

    assign pc_inc      = pc_q + PC_W'(1);
    assign cond_zero   = (cond == '0);
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign push_idx    = depth_q[AW-1:0];
    // Only consulted when the stack is non-empty, so the wrap at depth 0 is harmless.
    assign top_idx     = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        push_en = 1'b0;
        if (step) begin
            case (op)
                OP_NEXT: pc_d = pc_inc;
                OP_BRZ: begin
                    pc_d    = cond_zero ? br_target : pc_inc;
                    taken_d = cond_zero;
                end
                OP_BRNZ: begin
                    pc_d    = cond_zero ? pc_inc : br_target;
                    taken_d = ~cond_zero;
                end
                OP_JMP: begin
                    pc_d    = j_target;
                    taken_d = 1'b1;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        pc_d  = pc_inc;
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = j_target;
                        depth_d = depth_q + DW'(1);
                        taken_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[top_idx];
                        depth_d = depth_q - DW'(1);
                        taken_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_W'(RESET_PC);
            depth_q <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries above depth are never read, so the storage needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc    = pc_q;
    assign taken = taken_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (PC_W=12, STACK_DEPTH=4).
module tb_pc_sequencer;

    localparam logic [2:0] NEXT = 3'b000;
    localparam logic [2:0] BRZ  = 3'b001;
    localparam logic [2:0] BRNZ = 3'b010;
    localparam logic [2:0] JMP  = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic [2:0]  op;
    logic [15:0] cond;
    logic [11:0] br_target;
    logic [11:0] j_target;
    logic        err_clr;
    logic [11:0] pc;
    logic        taken;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .step      (step),
        .op        (op),
        .cond      (cond),
        .br_target (br_target),
        .j_target  (j_target),
        .err_clr   (err_clr),
        .pc        (pc),
        .taken     (taken),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] e_pc, input logic [2:0] e_depth,
                           input logic e_taken, input logic e_ovf, input logic e_unf);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".depth"}, 32'(depth), 32'(e_depth));
        chk({tag, ".taken"}, 32'(taken), 32'(e_taken));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, ".unf"}, 32'(unf), 32'(e_unf));
    endtask

    // Applies one op for exactly one rising edge, returns 1ns after that edge.
    task automatic run_op(input logic s, input logic [2:0] o, input logic [15:0] c,
                          input logic [11:0] bt, input logic [11:0] jt, input logic ec);
        step      = s;
        op        = o;
        cond      = c;
        br_target = bt;
        j_target  = jt;
        err_clr   = ec;
        @(posedge clk);
        #1;
        step    = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; op = NEXT; cond = '0;
        br_target = '0; j_target = '0; err_clr = 1'b0;
        #1;
        chk_all("reset", 12'h000, 3'd0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;

        // Sequential stepping
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("next1", 12'h001, 0, 0, 0, 0);
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("next2", 12'h002, 0, 0, 0, 0);
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("next3", 12'h003, 0, 0, 0, 0);
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("next4", 12'h004, 0, 0, 0, 0);
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("next5", 12'h005, 0, 0, 0, 0);

        // Branches
        run_op(1, JMP,  0,      0,      12'h007, 0); chk_all("jmp7",      12'h007, 0, 1, 0, 0);
        run_op(1, BRZ,  16'd0,  12'h020, 0,      0); chk_all("brz_take",  12'h020, 0, 1, 0, 0);
        run_op(1, BRZ,  16'd3,  12'h020, 0,      0); chk_all("brz_fall",  12'h021, 0, 0, 0, 0);
        run_op(1, BRNZ, 16'd3,  12'h040, 0,      0); chk_all("brnz_take", 12'h040, 0, 1, 0, 0);
        run_op(1, BRNZ, 16'd0,  12'h080, 0,      0); chk_all("brnz_fall", 12'h041, 0, 0, 0, 0);

        // No-step and HOLD codes
        run_op(0, JMP, 0, 0, 12'h300, 0); chk_all("nostep", 12'h041, 0, 0, 0, 0);
        run_op(1, 3'b110, 0, 0, 12'h300, 0); chk_all("hold6", 12'h041, 0, 0, 0, 0);
        run_op(1, 3'b111, 0, 0, 12'h300, 0); chk_all("hold7", 12'h041, 0, 0, 0, 0);

        // Wraparound of pc+1 and of the pushed return address
        run_op(1, JMP,  0, 0, 12'hFFF, 0); chk_all("jmpfff",   12'hFFF, 0, 1, 0, 0);
        run_op(1, NEXT, 0, 0, 0,       0); chk_all("wrapnext", 12'h000, 0, 0, 0, 0);
        run_op(1, JMP,  0, 0, 12'hFFF, 0); chk_all("jmpfff2",  12'hFFF, 0, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h100, 0); chk_all("wrapcall", 12'h100, 1, 1, 0, 0);
        run_op(1, RET,  0, 0, 0,       0); chk_all("wrapret",  12'h000, 0, 1, 0, 0);

        // Nested calls up to overflow, then returns down to underflow
        run_op(1, JMP,  0, 0, 12'h010, 0); chk_all("jmp010", 12'h010, 0, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h100, 0); chk_all("call1",  12'h100, 1, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h200, 0); chk_all("call2",  12'h200, 2, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h300, 0); chk_all("call3",  12'h300, 3, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h400, 0); chk_all("call4",  12'h400, 4, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h500, 0); chk_all("call5",  12'h401, 4, 0, 1, 0);
        run_op(1, RET,  0, 0, 0, 0);       chk_all("ret1",   12'h301, 3, 1, 1, 0);
        run_op(1, RET,  0, 0, 0, 0);       chk_all("ret2",   12'h201, 2, 1, 1, 0);
        run_op(1, RET,  0, 0, 0, 0);       chk_all("ret3",   12'h101, 1, 1, 1, 0);
        run_op(1, RET,  0, 0, 0, 0);       chk_all("ret4",   12'h011, 0, 1, 1, 0);
        run_op(1, RET,  0, 0, 0, 0);       chk_all("ret5",   12'h012, 0, 0, 1, 1);

        // Flag clearing: plain clear, set-wins, clear without step
        run_op(1, NEXT, 0, 0, 0, 1); chk_all("clr",       12'h013, 0, 0, 0, 0);
        run_op(1, RET,  0, 0, 0, 1); chk_all("clr_setw",  12'h014, 0, 0, 0, 1);
        run_op(0, RET,  0, 0, 0, 1); chk_all("clr_nostp", 12'h014, 0, 0, 0, 0);

        // Asynchronous reset mid-sequence with a populated stack
        run_op(1, CALL, 0, 0, 12'h100, 0); chk_all("pre1", 12'h100, 1, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h200, 0); chk_all("pre2", 12'h200, 2, 1, 0, 0);
        run_op(1, CALL, 0, 0, 12'h055, 0); chk_all("pre3", 12'h055, 3, 1, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("arst", 12'h000, 0, 0, 0, 0);
        #1 reset = 1'b0;
        run_op(1, RET,  0, 0, 0, 0); chk_all("post_ret",  12'h001, 0, 0, 0, 1);
        run_op(1, NEXT, 0, 0, 0, 0); chk_all("post_next", 12'h002, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12, program counter width in bits.
REQ-002 Parameter DATA_W, default 16, width of branch condition operand.
REQ-003 Parameter STACK_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 step  input  1  advance enable; when low no state changes.
REQ-008 op  input  3  operation: 000 NEXT, 001 BRZ, 010 BRNZ, 011 JMP, 100 CALL, 101 RET, 11x HOLD.
REQ-009 cond  input  DATA_W  branch condition operand, tested against zero.
REQ-010 br_target  input  PC_W  branch destination (register-sourced).
REQ-011 j_target  input  PC_W  jump/call destination (immediate-sourced).
REQ-012 err_clr  input  1  synchronous clear of sticky error flags.
REQ-013 pc  output  PC_W  current program counter, registered.
REQ-014 taken  output  1  one-cycle pulse: previous step caused a non-sequential PC load.
REQ-015 depth  output  clog2(STACK_DEPTH)+1  stack occupancy.
REQ-016 ovf  output  1  sticky: CALL attempted with stack full.
REQ-017 unf  output  1  sticky: RET attempted with stack empty.

Function
REQ-018 With step=1: NEXT sets pc <= pc+1.
REQ-019 BRZ sets pc <= br_target when cond==0, else pc+1; BRNZ inverts the test.
REQ-020 JMP sets pc <= j_target unconditionally.
REQ-021 CALL with depth<STACK_DEPTH pushes pc+1, sets pc <= j_target, depth+1.
REQ-022 CALL with depth==STACK_DEPTH: no push, pc <= pc+1, ovf set.
REQ-023 RET with depth>0 pops top entry into pc, depth-1.
REQ-024 RET with depth==0: pc <= pc+1, unf set, depth stays 0.
REQ-025 HOLD, or step=0: pc, depth, stack unchanged; taken <= 0.
REQ-026 pc+1 wraps modulo 2^PC_W (max value -> 0); pushed return address wraps identically.
REQ-027 Stack is LIFO; entries beyond depth are don't-care and never observable.
REQ-028 taken <= 1 the cycle after a taken BRZ/BRNZ, JMP, successful CALL or successful RET; 0 otherwise.
REQ-029 Latency: pc reflects an operation one clock edge after the step=1 cycle; back-to-back ops every cycle supported.
REQ-030 err_clr=1 clears ovf/unf; if the same cycle raises a flag, set wins.
REQ-031 Flags independent of step except they only set on stepped CALL/RET.
REQ-032 Unknown op codes (11x) behave as HOLD.

Reset
REQ-033 reset=1 forces pc=RESET_PC, depth=0, taken=0, ovf=0, unf=0 asynchronously, regardless of clock.
REQ-034 Reset asserted mid-sequence discards stack contents; first stepped op after deassertion acts on pc=RESET_PC.
REQ-035 Deassertion takes effect at the next rising edge; no op is executed on the deasserting edge unless step=1 is sampled after it.

Verification
REQ-036 Reset, 5 steps NEXT -> pc=0,1,2,3,4,5; taken=0 throughout.
REQ-037 pc=7, BRZ cond=0 br_target=0x020 -> pc=0x020, taken=1; then BRZ cond=3 -> pc=0x021, taken=0.
REQ-038 PC_W=12, pc=0xFFF, NEXT -> pc=0x000; CALL j_target=0x100 at pc=0xFFF pushes 0x000, RET -> pc=0x000.
REQ-039 Five nested CALLs (STACK_DEPTH=4) -> depth=4, fifth gives ovf=1, pc=prior+1; four RETs return in reverse order; fifth RET -> unf=1, depth=0.
REQ-040 Assert reset asynchronously between clock edges with depth=3, pc=0x055 -> pc=0x000, depth=0 immediately; err_clr with simultaneous failing RET -> unf remains 1.
